// File: rtl/imm_gen_pkg.sv
// Shared opcode, immediate-format and buffer-state encodings for the
// immediate generator pipeline.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } bufState_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: builds the XLEN-wide immediate, the format
// code and the illegal flag from a single instruction word.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        isShift;
  logic [63:0] immI, immS, immB, immU, immJ, shamtX, shamtW, imm64;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign isShift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  // All candidates are built at 64 bits and truncated once, so the XLEN=32
  // build needs no zero-width replications.
  assign immI   = {{52{instr_i[31]}}, instr_i[31:20]};
  assign immS   = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign immB   = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign immU   = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
  assign immJ   = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign shamtX = (XLEN == 64) ? {58'd0, instr_i[25:20]} : {59'd0, instr_i[24:20]};
  assign shamtW = {59'd0, instr_i[24:20]};

  always_comb begin
    imm64     = '0;
    fmt_o     = FMT_ILL;
    illegal_o = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm64 = immI; fmt_o = FMT_I; illegal_o = 1'b0;
      end
      OPC_OP_IMM: begin
        imm64 = isShift ? shamtX : immI; fmt_o = FMT_I; illegal_o = 1'b0;
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          imm64 = isShift ? shamtW : immI; fmt_o = FMT_I; illegal_o = 1'b0;
        end
      end
      OPC_STORE: begin
        imm64 = immS; fmt_o = FMT_S; illegal_o = 1'b0;
      end
      OPC_BRANCH: begin
        imm64 = immB; fmt_o = FMT_B; illegal_o = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm64 = immU; fmt_o = FMT_U; illegal_o = 1'b0;
      end
      OPC_JAL: begin
        imm64 = immJ; fmt_o = FMT_J; illegal_o = 1'b0;
      end
      OPC_OP: begin
        fmt_o = FMT_R; illegal_o = 1'b0;
      end
      OPC_OP_32: begin
        if (RV64) begin
          fmt_o = FMT_R; illegal_o = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign imm_o = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry skid buffer: decodes on the way in and
// holds up to two results while the consumer stalls.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  logic [XLEN-1:0] decImm;
  fmt_e            decFmt;
  logic            decIll;

  bufState_e       state_q, state_d;
  logic            inReady_q;
  logic [XLEN-1:0] mainImm_q, skidImm_q;
  logic [2:0]      mainFmt_q, skidFmt_q;
  logic            mainIll_q, skidIll_q;
  logic [31:0]     mainInstr_q, skidInstr_q;

  logic inXfer, outXfer, loadMain, loadSkid, skidToMain;

  imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_decode (
    .instr_i   (in_instr),
    .imm_o     (decImm),
    .fmt_o     (decFmt),
    .illegal_o (decIll)
  );

  assign inXfer  = in_valid && inReady_q;
  assign outXfer = (state_q != ST_EMPTY) && out_ready;

  // Flush wins over everything, including an input accepted in the same cycle.
  always_comb begin
    state_d    = state_q;
    loadMain   = 1'b0;
    loadSkid   = 1'b0;
    skidToMain = 1'b0;
    case (state_q)
      ST_EMPTY: if (inXfer) begin state_d = ST_ONE; loadMain = 1'b1; end
      ST_ONE: begin
        if (inXfer && outXfer)  loadMain = 1'b1;
        else if (inXfer)        begin state_d = ST_TWO; loadSkid = 1'b1; end
        else if (outXfer)       state_d = ST_EMPTY;
      end
      ST_TWO: if (outXfer) begin state_d = ST_ONE; skidToMain = 1'b1; end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d    = ST_EMPTY;
      loadMain   = 1'b0;
      loadSkid   = 1'b0;
      skidToMain = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      inReady_q   <= 1'b0;
      mainImm_q   <= '0;
      mainFmt_q   <= '0;
      mainIll_q   <= 1'b0;
      mainInstr_q <= '0;
      skidImm_q   <= '0;
      skidFmt_q   <= '0;
      skidIll_q   <= 1'b0;
      skidInstr_q <= '0;
    end else begin
      state_q   <= state_d;
      inReady_q <= (state_d != ST_TWO);
      if (loadMain) begin
        mainImm_q   <= decImm;
        mainFmt_q   <= decFmt;
        mainIll_q   <= decIll;
        mainInstr_q <= in_instr;
      end else if (skidToMain) begin
        mainImm_q   <= skidImm_q;
        mainFmt_q   <= skidFmt_q;
        mainIll_q   <= skidIll_q;
        mainInstr_q <= skidInstr_q;
      end
      if (loadSkid) begin
        skidImm_q   <= decImm;
        skidFmt_q   <= decFmt;
        skidIll_q   <= decIll;
        skidInstr_q <= in_instr;
      end
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_imm     = mainImm_q;
  assign out_fmt     = mainFmt_q;
  assign out_illegal = mainIll_q;
  assign out_instr   = mainInstr_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed scenarios plus randomized traffic checked
// against an arithmetic immediate model and an in-order queue of accepted words.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_instr;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [31:0] out_instr32;

  int nTests = 0;
  int nFail  = 0;
  logic [31:0] q[$];
  bit mReady = 1'b0;

  imm_gen_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_instr(out_instr)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_instr(out_instr32)
  );

  always #5 clk = ~clk;

  // Immediates are assembled as weighted sums of instruction fields, with the
  // sign bit contributing a negative power of two.
  function automatic logic [63:0] refImm(input logic [31:0] ins, input bit is64);
    longint v;
    longint s;
    logic [63:0] r;
    int f3;
    s  = ins[31] ? 64'sd1 : 64'sd0;
    f3 = int'(ins[14:12]);
    v  = 0;
    case (ins[6:0])
      7'h03, 7'h67: v = longint'(ins[30:20]) - s * 2048;
      7'h13: begin
        if (f3 == 1 || f3 == 5) v = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
        else v = longint'(ins[30:20]) - s * 2048;
      end
      7'h1B: begin
        if (is64) begin
          if (f3 == 1 || f3 == 5) v = longint'(ins[24:20]);
          else v = longint'(ins[30:20]) - s * 2048;
        end
      end
      7'h23: v = longint'(ins[11:7]) + longint'(ins[30:25]) * 32 - s * 2048;
      7'h63: v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32
                 + longint'(ins[7]) * 2048 - s * 4096;
      7'h37, 7'h17: v = longint'(ins[30:12]) * 4096 - s * 64'sd2147483648;
      7'h6F: v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
                 + longint'(ins[19:12]) * 4096 - s * 1048576;
      default: v = 0;
    endcase
    r = v;
    if (!is64) r[63:32] = 32'h0;
    return r;
  endfunction

  function automatic logic [2:0] refFmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h1B: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h33, 7'h3B:               return 3'd0;
      default:                    return 3'd7;
    endcase
  endfunction

  // One clock edge: update the queue model from the inputs in force at the edge.
  task automatic tick();
    bit inX, outX;
    @(posedge clk);
    inX  = in_valid && mReady && (q.size() < 2);
    outX = out_ready && (q.size() > 0);
    if (rst) begin
      q.delete();
      mReady = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        if (outX) void'(q.pop_front());
        if (inX) q.push_back(in_instr);
      end
      mReady = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    nTests++; if (out_imm !== 64'h0 || out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_instr !== 32'h0) begin
      nFail++; $display("[TB] FAIL reset_data: imm %h fmt %0d ill %b instr %h want zeros", out_imm, out_fmt, out_illegal, out_instr);
    end
    tick();
    #2 rst = 1'b0;
    nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL ready_before_edge: got %b want 0", in_ready); end
    tick();
    nTests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nFail++; $display("[TB] FAIL ready_after_edge: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFF410093;
    tick();
    in_valid = 1'b0;
    nTests++; if (out_valid !== 1'b1 || out_imm !== 64'hFFFFFFFFFFFFFFF4 || out_fmt !== 3'd1 || out_illegal !== 1'b0) begin
      nFail++; $display("[TB] FAIL addi: valid %b imm %h fmt %0d want 1 FFFFFFFFFFFFFFF4 1", out_valid, out_imm, out_fmt);
    end
    tick();
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL addi_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins  [3] = '{32'hFE112623, 32'hFE2088E3, 32'h001000EF};
    logic [63:0] imms [3] = '{64'hFFFFFFFFFFFFFFEC, 64'hFFFFFFFFFFFFFFF0, 64'h0000000000000800};
    logic [2:0]  fmts [3] = '{3'd2, 3'd3, 3'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = ins[i];
      tick();
      nTests++; if (out_valid !== 1'b1 || out_instr !== ins[i] || out_imm !== imms[i] || out_fmt !== fmts[i] || in_ready !== 1'b1) begin
        nFail++; $display("[TB] FAIL b2b_%0d: valid %b instr %h imm %h fmt %0d ready %b want 1 %h %h %0d 1",
                          i, out_valid, out_instr, out_imm, out_fmt, in_ready, ins[i], imms[i], fmts[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_utype_shift();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h800002B7;
    tick();
    nTests++; if (out_imm !== 64'hFFFFFFFF80000000 || out_fmt !== 3'd4) begin
      nFail++; $display("[TB] FAIL lui64: imm %h fmt %0d want FFFFFFFF80000000 4", out_imm, out_fmt);
    end
    nTests++; if (out_imm32 !== 32'h80000000) begin
      nFail++; $display("[TB] FAIL lui32: imm %h want 80000000", out_imm32);
    end
    in_instr = 32'h03F11093;
    tick();
    nTests++; if (out_imm !== 64'h3F || out_fmt !== 3'd1) begin
      nFail++; $display("[TB] FAIL slli: imm %h fmt %0d want 3F 1", out_imm, out_fmt);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3] = '{32'h00500093, 32'h00A00113, 32'h00F00193};
    logic [31:0] got[$];
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ins[0];
    tick();
    in_instr = ins[1];
    tick();
    nTests++; if (in_ready !== 1'b0 || out_instr !== ins[0]) begin
      nFail++; $display("[TB] FAIL bp_full: ready %b instr %h want 0 %h", in_ready, out_instr, ins[0]);
    end
    in_instr = ins[2];
    tick();
    nTests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== ins[0]) begin
      nFail++; $display("[TB] FAIL bp_hold: ready %b valid %b instr %h want 0 1 %h", in_ready, out_valid, out_instr, ins[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      bit accC;
      accC = in_valid && in_ready;
      if (out_valid) got.push_back(out_instr);
      tick();
      if (accC) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    nTests++; if (got.size() != 3) begin
      nFail++; $display("[TB] FAIL bp_count: got %0d entries want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nTests++; if (got[i] !== ins[i]) begin
          nFail++; $display("[TB] FAIL bp_order_%0d: got %h want %h", i, got[i], ins[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
    tick();
    in_instr = 32'h00A00113;
    tick();
    in_valid = 1'b0;
    nTests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL flush_setup: valid %b ready %b want 1 0", out_valid, in_ready);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nTests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL flush_two: valid %b ready %b want 0 1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_instr = 32'h00F00193; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nTests++; if (out_valid !== 1'b0) begin
      nFail++; $display("[TB] FAIL flush_override: valid %b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    nTests++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== 64'h0 || out_instr !== 32'h7F) begin
      nFail++; $display("[TB] FAIL illegal: valid %b ill %b fmt %0d imm %h instr %h want 1 1 7 0 7F",
                        out_valid, out_illegal, out_fmt, out_imm, out_instr);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFF410093;
    tick();
    in_valid = 1'b0;
    nTests++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL arst_setup: valid %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    nTests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== 64'h0) begin
      nFail++; $display("[TB] FAIL arst_immediate: valid %b ready %b imm %h want 0 0 0", out_valid, in_ready, out_imm);
    end
    #1 rst = 1'b0;
    q.delete();
    mReady = 1'b0;
    tick();
    nTests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL arst_recover: valid %b ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [14] = '{7'h03, 7'h13, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};
    logic [31:0] r;
    logic [31:0] exp;
    for (int c = 0; c < 400; c++) begin
      r         = $urandom();
      in_instr  = {r[31:7], opcs[$urandom_range(0, 13)]};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
      nTests++; if (out_valid !== (q.size() > 0)) begin
        nFail++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, out_valid, q.size() > 0);
      end
      nTests++; if (in_ready !== (q.size() < 2)) begin
        nFail++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, in_ready, q.size() < 2);
      end
      if (q.size() > 0) begin
        exp = q[0];
        nTests++; if (out_instr !== exp) begin
          nFail++; $display("[TB] FAIL rnd_instr c%0d: got %h want %h", c, out_instr, exp);
        end
        nTests++; if (out_imm !== refImm(exp, 1'b1) || out_fmt !== refFmt(exp) || out_illegal !== (refFmt(exp) == 3'd7)) begin
          nFail++; $display("[TB] FAIL rnd_decode c%0d: instr %h imm %h fmt %0d ill %b want %h %0d %b",
                            c, exp, out_imm, out_fmt, out_illegal, refImm(exp, 1'b1), refFmt(exp), refFmt(exp) == 3'd7);
        end
        nTests++; if (out_imm32 !== refImm(exp, 1'b0)) begin
          nFail++; $display("[TB] FAIL rnd_imm32 c%0d: instr %h got %h want %h", c, exp, out_imm32, refImm(exp, 1'b0));
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_utype_shift();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter RV64, default (XLEN==64), which enables the OP-IMM-32 (0011011) decode.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_instr is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an instruction; registered.
REQ-007 SHALL have port in_instr, input, 32 bits: instruction word.
REQ-008 SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-009 SHALL have port out_valid, output, 1 bit: the output entry is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the output entry.
REQ-011 SHALL have port out_imm, output, XLEN bits: sign- or zero-extended immediate.
REQ-012 SHALL have port out_fmt, output, 3 bits: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-013 SHALL have port out_illegal, output, 1 bit: the opcode is not decoded.
REQ-014 SHALL have port out_instr, output, 32 bits: the instruction passed through with its decode.

Function
REQ-015 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-016 Decode SHALL be combinational on in_instr; the result is written into a 2-entry buffer (main register plus skid register).
REQ-017 Latency: an accepted instruction SHALL appear on out_* the next cycle when the buffer is empty.
REQ-018 State machine states: EMPTY, ONE, TWO.
- EMPTY: in_ready=1, out_valid=0.
- ONE: in_ready=1, out_valid=1.
- TWO: in_ready=0, out_valid=1.
REQ-019 Transitions:
- EMPTY -> ONE on input transfer.
- ONE -> TWO on input transfer without output transfer.
- ONE -> EMPTY on output transfer without input transfer.
- ONE holds on simultaneous input and output transfer, with the main register reloaded.
- TWO -> ONE on output transfer; the skid entry moves to main.
REQ-020 Ordering: entries SHALL leave in acceptance order; no loss and no duplication.
REQ-021 Output stability: while out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-022 flush SHALL force EMPTY on the next edge and override a same-cycle input transfer. in_ready stays registered, so in_ready may be 1 in that cycle and the entry is still discarded.
REQ-023 Immediate by opcode (instr[6:0]), sign bit instr[31], extended to XLEN:
- I-type, fmt I: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR.
- S-type, fmt S: 0100011.
- B-type, fmt B: 1100011; bit 0 is zero.
- U-type, fmt U: 0110111 LUI, 0010111 AUIPC; bits [11:0] are zero.
- J-type, fmt J: 1101111; bit 0 is zero.
- R-type, fmt R, imm 0: 0110011, 0111011.
REQ-024 Shifts: OP-IMM with funct3 001/101 SHALL give zero-extended shamt, instr[25:20] when XLEN=64 and instr[24:20] when XLEN=32. OP-IMM-32 shifts SHALL give instr[24:20].
REQ-025 OP-IMM-32 SHALL decode as I-type when RV64=1, otherwise as illegal; 0111011 is likewise illegal when RV64=0.
REQ-026 Any other opcode SHALL give out_illegal=1, out_fmt=7, out_imm=0; the entry is still delivered in order.

Reset
REQ-027 While rst=1, the block SHALL be in EMPTY immediately (asynchronous) with: out_valid=0, in_ready=0, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0.
REQ-028 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; no partial output is delivered.

Structure
REQ-030 The shared header imm_gen_pkg SHALL hold the opcode constants, the fmt encodings (FMT_R..FMT_ILL) and the state encodings.
REQ-031 The combinational decoder SHALL be a separate sub-module, imm_decode, parameterised by XLEN and RV64, instanced once ahead of the buffer.

Verification
REQ-032 ADDI 0xFF410093, out_ready=1 -> one cycle later: out_imm=FFFFFFFFFFFFFFF4, fmt=1.
REQ-033 Back-to-back stream with out_ready=1 -> one result per cycle, 1-cycle latency:
- SW 0xFE112623 -> FFFFFFFFFFFFFFEC, fmt=2.
- BEQ 0xFE2088E3 -> FFFFFFFFFFFFFFF0, fmt=3.
- JAL 0x001000EF -> 0000000000000800, fmt=5.
REQ-034 U-type and shift cases, XLEN=64:
- LUI 0x800002B7 -> FFFFFFFF80000000.
- SLLI 0x03F11093 -> 000000000000003F.
- XLEN=32 build, LUI 0x800002B7 -> 80000000.
REQ-035 Backpressure: out_ready=0 while three instructions are offered -> two accepted, in_ready=0 after the second; then out_ready=1 -> all three emerge in order.
REQ-036 Flush and illegal:
- flush in TWO -> next cycle out_valid=0, in_ready=1.
- 0x0000007F -> out_illegal=1, fmt=7, imm=0.
REQ-037 Asynchronous rst pulse between clock edges in state ONE -> out_valid=0 immediately.
